// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
// Holds the load FSM state encoding, the NOP fill word and byte-lane helpers.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [31:0] NOP_WORD_C = 32'h0000_0013;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

   // Places byte b into the given lane; lanes above it come back zero,
   // which gives the zero padding of a short final word for free.
   function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = 32'h0;
      unique case (lane)
         LANE0:   r = {24'h0, b};
         LANE1:   r = {16'h0, b, word[7:0]};
         LANE2:   r = {8'h0, b, word[15:0]};
         default: r = {b, word[23:0]};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module imem_array #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory in front of the core's fetch stage, filled through a
// byte-serial boot port; the core is held in reset until an image is loaded.
module imem_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH    = 32,
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [31:0]       fetch_data,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   input  logic              load_last,
   output logic              load_ready,
   output logic              core_rst_n,
   output logic              overflow,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [1:0]        bytecnt_q, bytecnt_d;
   logic [31:0]       asm_q, asm_d;
   logic              overflow_q, overflow_d;
   logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
   logic              core_rst_n_q, core_rst_n_d;

   logic              mem_we;
   logic [31:0]       merged;
   logic [31:0]       rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wptr_q         <= '0;
         bytecnt_q      <= LANE0;
         asm_q          <= '0;
         overflow_q     <= 1'b0;
         words_loaded_q <= '0;
         core_rst_n_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         wptr_q         <= wptr_d;
         bytecnt_q      <= bytecnt_d;
         asm_q          <= asm_d;
         overflow_q     <= overflow_d;
         words_loaded_q <= words_loaded_d;
         core_rst_n_q   <= core_rst_n_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wptr_d         = wptr_q;
      bytecnt_d      = bytecnt_q;
      asm_d          = asm_q;
      overflow_d     = overflow_q;
      words_loaded_d = words_loaded_q;
      mem_we         = 1'b0;
      merged         = merge_byte(asm_q, bytecnt_q, load_byte);

      // load_start takes priority over any byte offered in the same cycle
      if (load_start) begin
         state_d        = ST_LOAD;
         wptr_d         = '0;
         bytecnt_d      = LANE0;
         asm_d          = '0;
         overflow_d     = 1'b0;
         words_loaded_d = '0;
      end else if (state_q == ST_LOAD && load_valid) begin
         if (bytecnt_q == LANE3 || load_last) begin
            asm_d     = '0;
            bytecnt_d = LANE0;
            if (wptr_q < DEPTH_W) begin
               mem_we = 1'b1;
               wptr_d = wptr_q + 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
            if (load_last) begin
               state_d        = ST_RUN;
               words_loaded_d = wptr_d;
            end
         end else begin
            asm_d     = merged;
            bytecnt_d = bytecnt_q + 2'd1;
         end
      end

      // Registered so the core leaves reset one cycle after the final write,
      // but drops immediately on the edge that starts a reload.
      core_rst_n_d = (state_q == ST_RUN) && !load_start;
   end

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr_q[AW-1:0]),
      .wdata (merged),
      .raddr (fetch_addr[AW-1:0]),
      .rdata (rdata)
   );

   assign fetch_data   = (state_q == ST_RUN && {1'b0, fetch_addr} < words_loaded_q)
                         ? rdata : NOP_WORD;
   assign load_ready   = (state_q == ST_LOAD);
   assign core_rst_n   = core_rst_n_q;
   assign overflow     = overflow_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against an image-level
// reference model (byte list -> packed words, count, overflow).
module tb_imem_loader;

   localparam int          DEPTH  = 4;
   localparam int          ADDR_W = 8;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] fetch_addr;
   logic [31:0]       fetch_data;
   logic              load_start;
   logic              load_valid;
   logic [7:0]        load_byte;
   logic              load_last;
   logic              load_ready;
   logic              core_rst_n;
   logic              overflow;
   logic [ADDR_W:0]   words_loaded;

   always #5 clk = ~clk;

   imem_loader #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .NOP_WORD (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_addr   (fetch_addr),
      .fetch_data   (fetch_data),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_byte    (load_byte),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .core_rst_n   (core_rst_n),
      .overflow     (overflow),
      .words_loaded (words_loaded)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_mem [DEPTH];
   int          exp_wl  = 0;
   bit          exp_ovf = 0;
   bit          exp_run = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_fetch(input int a);
      if (exp_run && a < exp_wl) return exp_mem[a];
      return NOP;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input bit junk);
      load_start = 1'b1;
      load_valid = junk;
      load_byte  = 8'hEE;
      load_last  = 1'b0;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      exp_run    = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic check_fetch(input string tag);
      int addrs [DEPTH+3];
      for (int i = 0; i <= DEPTH + 1; i++) addrs[i] = i;
      addrs[DEPTH+2] = int'($urandom_range(255));
      foreach (addrs[i]) begin
         fetch_addr = addrs[i][ADDR_W-1:0];
         @(negedge clk);
         check(tag, fetch_data, exp_fetch(addrs[i]));
         tick();
      end
   endtask

   // Loads an image, updates the model from the byte list, checks status and reads back.
   task automatic run_image(input logic [7:0] img[$], input int gap_pct, input bit junk);
      int nw;
      logic [31:0] w;
      start_load(junk);
      check("ld_ready", {31'h0, load_ready}, 32'h1);
      check("ld_core_held", {31'h0, core_rst_n}, 32'h0);
      check("ld_wl_clear", {23'h0, words_loaded}, 32'h0);
      check("ld_ovf_clear", {31'h0, overflow}, 32'h0);
      for (int i = 0; i < img.size(); i++) begin
         while (int'($urandom_range(99)) < gap_pct) tick();
         send_byte(img[i], i == img.size() - 1);
         if (i == 0 && img.size() > 1) begin
            fetch_addr = '0;
            #1;
            check("ld_fetch_nop", fetch_data, NOP);
         end
      end
      nw = (img.size() + 3) / 4;
      for (int j = 0; j < nw && j < DEPTH; j++) begin
         w = '0;
         for (int k = 0; k < 4; k++)
            if (4 * j + k < img.size()) w = w | (32'(img[4*j+k]) << (8 * k));
         exp_mem[j] = w;
      end
      exp_wl  = (nw < DEPTH) ? nw : DEPTH;
      exp_ovf = (nw > DEPTH);
      exp_run = 1;
      check("done_core_still_held", {31'h0, core_rst_n}, 32'h0);
      check("done_ready_low", {31'h0, load_ready}, 32'h0);
      check("done_wl", {23'h0, words_loaded}, 32'(exp_wl));
      check("done_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
      tick();
      check("run_core_released", {31'h0, core_rst_n}, 32'h1);
      check_fetch("run_fetch");
   endtask

   function automatic void rand_image(output logic [7:0] img[$], input int nbytes);
      img = {};
      for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom));
   endfunction

   initial begin
      logic [7:0] img[$];
      rst_n      = 1'b0;
      fetch_addr = '0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_byte  = '0;
      load_last  = 1'b0;
      #1;
      check("rst_fetch", fetch_data, NOP);
      check("rst_core", {31'h0, core_rst_n}, 32'h0);
      check("rst_ready", {31'h0, load_ready}, 32'h0);
      check("rst_ovf", {31'h0, overflow}, 32'h0);
      check("rst_wl", {23'h0, words_loaded}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_ready", {31'h0, load_ready}, 32'h0);
      check("idle_fetch", fetch_data, NOP);

      img = '{8'h93, 8'h00, 8'h10, 8'h00};
      run_image(img, 0, 0);
      fetch_addr = 8'd0;
      #1;
      check("addi_word", fetch_data, 32'h0010_0093);
      fetch_addr = 8'd1;
      #1;
      check("addi_beyond", fetch_data, NOP);

      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAB};
      run_image(img, 0, 0);
      fetch_addr = 8'd2;
      #1;
      check("pad_word", fetch_data, 32'h0000_00AB);
      check("pad_wl", {23'h0, words_loaded}, 32'd3);

      rand_image(img, 20);
      run_image(img, 0, 0);
      check("ovf_flag", {31'h0, overflow}, 32'h1);
      check("ovf_wl", {23'h0, words_loaded}, 32'd4);
      fetch_addr = 8'd4;
      #1;
      check("ovf_fetch4", fetch_data, NOP);

      rand_image(img, 8);
      run_image(img, 0, 0);
      start_load(0);
      check("reload_core_drop", {31'h0, core_rst_n}, 32'h0);
      fetch_addr = 8'd0;
      #1;
      check("reload_fetch_nop", fetch_data, NOP);
      rand_image(img, 4);
      run_image(img, 0, 0);
      fetch_addr = 8'd1;
      #1;
      check("reload_fetch1", fetch_data, NOP);

      start_load(0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      run_image(img, 0, 0);
      fetch_addr = 8'd0;
      #1;
      check("restart_word0", fetch_data, 32'hD4C3_B2A1);

      img = '{8'h55, 8'h66, 8'h77, 8'h88};
      run_image(img, 0, 1);
      fetch_addr = 8'd0;
      #1;
      check("coincide_word0", fetch_data, 32'h8877_6655);

      start_load(0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      rst_n = 1'b0;
      exp_run = 0;
      #2;
      check("midrst_ready", {31'h0, load_ready}, 32'h0);
      check("midrst_core", {31'h0, core_rst_n}, 32'h0);
      check("midrst_fetch", fetch_data, NOP);
      check("midrst_wl", {23'h0, words_loaded}, 32'h0);
      #1;
      rst_n = 1'b1;
      tick();
      check("midrst_idle_ready", {31'h0, load_ready}, 32'h0);
      img = '{8'h01, 8'h23, 8'h45, 8'h67};
      run_image(img, 0, 0);
      fetch_addr = 8'd0;
      #1;
      check("midrst_word0", fetch_data, 32'h6745_2301);

      for (int it = 0; it < 15; it++) begin
         rand_image(img, int'($urandom_range(1, (DEPTH + 2) * 4)));
         run_image(img, 30, it[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
